// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg : shared constants and types for the register-file write-back path
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package rf_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 32;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    logic            valid;
    reg_idx_t        rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard : pending multi-cycle result tracker with two query ports
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module rf_scoreboard
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       set_en,
  input  logic [4:0] set_idx,
  input  logic       clr_en,
  input  logic [4:0] clr_idx,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       rs1_busy,
  output logic       rs2_busy
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] busy_next;

  // Set is applied after clear so a same-cycle issue to the retiring register keeps it busy.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_idx] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
    busy_next    = (busy & ~clr_mask) | set_mask;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign rs1_busy = busy[rs1];
  assign rs2_busy = busy[rs2];

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter : merges pipeline and multi-cycle write-backs onto one RF port
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int XLEN     = rf_pkg::XLEN,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_stall,

  input  logic            mc_valid,
  output logic            mc_ready,
  input  logic [4:0]      mc_rd,
  input  logic [XLEN-1:0] mc_data,

  input  logic            mc_issue,
  input  logic [4:0]      mc_issue_rd,

  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,

  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  wb_req_t    alu_req;
  wb_req_t    mc_req;
  wb_req_t    win_req;
  wb_req_t    commit_q;
  logic [3:0] wait_cnt;
  logic       starve;
  logic       alu_accept;
  logic       mc_accept;

  assign alu_req = '{valid: alu_valid, rd: alu_rd, data: alu_data};
  assign mc_req  = '{valid: mc_valid,  rd: mc_rd,  data: mc_data};

  // Pipeline owns the port unless the multi-cycle unit has been refused MAX_WAIT times.
  assign starve     = (wait_cnt == WAIT_LIMIT);
  assign mc_ready   = !alu_valid || starve;
  assign alu_stall  = alu_valid && mc_valid && starve;
  assign alu_accept = alu_valid && !alu_stall;
  assign mc_accept  = mc_valid && mc_ready;

  always_comb begin
    win_req = alu_req;
    if (mc_accept) win_req = mc_req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (mc_accept || !mc_valid) begin
      wait_cnt <= '0;
    end else if (!starve) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // x0 writes still complete the handshake; only the write enable is suppressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      commit_q <= '0;
    end else if (alu_accept || mc_accept) begin
      commit_q.valid <= win_req.valid && (win_req.rd != 5'd0);
      commit_q.rd    <= win_req.rd;
      commit_q.data  <= win_req.data;
    end else begin
      commit_q.valid <= 1'b0;
    end
  end

  assign rf_we    = commit_q.valid;
  assign rf_waddr = commit_q.rd;
  assign rf_wdata = commit_q.data;

  rf_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (mc_issue),
    .set_idx  (mc_issue_rd),
    .clr_en   (mc_accept),
    .clr_idx  (mc_rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_arbiter : vector table plus hand sequences, commit checked via queue
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        alu_stall;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_rd;
  logic [63:0] mc_data;
  logic        mc_issue;
  logic [4:0]  mc_issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;

  rf_wb_arbiter #(.XLEN(64), .MAX_WAIT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_stall   (alu_stall),
    .mc_valid    (mc_valid),
    .mc_ready    (mc_ready),
    .mc_rd       (mc_rd),
    .mc_data     (mc_data),
    .mc_issue    (mc_issue),
    .mc_issue_rd (mc_issue_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ard;
    logic [63:0] adat;
    logic        mv;
    logic [4:0]  mrd;
    logic [63:0] mdat;
    logic        iss;
    logic [4:0]  ird;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_rdy;
    logic        e_stall;
    logic        e_b1;
    logic        e_b2;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [63:0] e_wd;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input int rst, input int av, input int ard, input longint adat,
                              input int mv, input int mrd, input longint mdat,
                              input int iss, input int ird, input int r1, input int r2,
                              input int rdy, input int stl, input int b1, input int b2,
                              input int we, input int wa, input longint wd);
    vec_t v;
    v.rst = 1'(rst);  v.av = 1'(av);   v.ard = 5'(ard);  v.adat = 64'(adat);
    v.mv = 1'(mv);    v.mrd = 5'(mrd); v.mdat = 64'(mdat);
    v.iss = 1'(iss);  v.ird = 5'(ird); v.r1 = 5'(r1);    v.r2 = 5'(r2);
    v.e_rdy = 1'(rdy); v.e_stall = 1'(stl); v.e_b1 = 1'(b1); v.e_b2 = 1'(b2);
    v.e_we = 1'(we);  v.e_wa = 5'(wa); v.e_wd = 64'(wd);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    reset = v.rst;  alu_valid = v.av; alu_rd = v.ard; alu_data = v.adat;
    mc_valid = v.mv; mc_rd = v.mrd;   mc_data = v.mdat;
    mc_issue = v.iss; mc_issue_rd = v.ird; rs1 = v.r1; rs2 = v.r2;
    #1;
    chk("mc_ready",  64'(mc_ready),  64'(v.e_rdy));
    chk("alu_stall", 64'(alu_stall), 64'(v.e_stall));
    chk("rs1_busy",  64'(rs1_busy),  64'(v.e_b1));
    chk("rs2_busy",  64'(rs2_busy),  64'(v.e_b2));
    exp_q.push_back('{we: v.e_we, wa: v.e_wa, wd: v.e_wd});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL commit_queue: got empty required one entry");
    end else begin
      e = exp_q.pop_front();
      chk("rf_we",    64'(rf_we),    64'(e.we));
      chk("rf_waddr", 64'(rf_waddr), 64'(e.wa));
      chk("rf_wdata", rf_wdata,      e.wd);
    end
  endtask

  initial begin
    reset = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mc_valid = 1'b0; mc_rd = '0; mc_data = '0;
    mc_issue = 1'b0; mc_issue_rd = '0; rs1 = '0; rs2 = '0;

    // rst av ard adat   mv mrd mdat   iss ird r1 r2  rdy stl b1 b2  we wa wd
    tbl.push_back(mk(1, 0, 0, 0,       0, 0, 0,       0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,       0, 0, 0,       0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 5, 'h1234,  0, 0, 0,       0, 0, 0, 0,  0, 0, 0, 0,  1, 5, 'h1234));
    tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0,       0, 0, 0, 0,  1, 0, 0, 0,  0, 5, 'h1234));
    tbl.push_back(mk(0, 0, 0, 0,       1, 6, 'hABCD,  0, 0, 0, 0,  1, 0, 0, 0,  1, 6, 'hABCD));
    tbl.push_back(mk(0, 1, 0, 'h55,    0, 0, 0,       0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 'h55));
    tbl.push_back(mk(0, 0, 0, 0,       1, 0, 'h66,    0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 'h66));
    tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0,       1, 9, 9, 0,  1, 0, 0, 0,  0, 0, 'h66));
    tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0,       0, 0, 9, 9,  1, 0, 1, 1,  0, 0, 'h66));
    tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0,       1, 0, 0, 9,  1, 0, 0, 1,  0, 0, 'h66));
    tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0,       0, 0, 0, 9,  1, 0, 0, 1,  0, 0, 'h66));
    tbl.push_back(mk(0, 0, 0, 0,       1, 9, 'h99,    0, 0, 9, 0,  1, 0, 1, 0,  1, 9, 'h99));
    tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0,       0, 0, 9, 0,  1, 0, 0, 0,  0, 9, 'h99));
    tbl.push_back(mk(0, 0, 0, 0,       1, 3, 'h33,    1, 3, 3, 0,  1, 0, 0, 0,  1, 3, 'h33));
    tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0,       0, 0, 3, 0,  1, 0, 1, 0,  0, 3, 'h33));
    tbl.push_back(mk(0, 0, 0, 0,       1, 3, 'h34,    0, 0, 3, 0,  1, 0, 1, 0,  1, 3, 'h34));
    tbl.push_back(mk(0, 0, 0, 0,       0, 0, 0,       0, 0, 3, 0,  1, 0, 0, 0,  0, 3, 'h34));

    foreach (tbl[i]) apply(tbl[i]);

    // Contention: four refusals, then the multi-cycle unit pre-empts the pipeline.
    for (int i = 1; i <= 4; i++)
      apply(mk(0, 1, i, 'h100 + i, 1, 7, 'h777, 0, 0, 0, 0, 0, 0, 0, 0, 1, i, 'h100 + i));
    apply(mk(0, 1, 5, 'h105, 1, 7, 'h777, 0, 0, 0, 0,  1, 1, 0, 0,  1, 7, 'h777));
    apply(mk(0, 1, 5, 'h105, 0, 0, 0,     0, 0, 0, 0,  0, 0, 0, 0,  1, 5, 'h105));
    apply(mk(0, 1, 6, 'h106, 1, 8, 'h888, 0, 0, 0, 0,  0, 0, 0, 0,  1, 6, 'h106));
    apply(mk(0, 0, 0, 0,     1, 8, 'h888, 0, 0, 0, 0,  1, 0, 0, 0,  1, 8, 'h888));

    // Reset while the wait counter is part-way: refusal count restarts from zero.
    apply(mk(0, 1, 10, 'hA0, 1, 12, 'hC, 1, 12, 0, 0,  0, 0, 0, 0,  1, 10, 'hA0));
    apply(mk(0, 1, 11, 'hA1, 1, 12, 'hC, 0, 0, 12, 0,  0, 0, 1, 0,  1, 11, 'hA1));
    apply(mk(1, 1, 13, 'hA3, 1, 12, 'hC, 0, 0, 12, 0,  0, 0, 1, 0,  0, 0, 0));
    for (int i = 0; i < 4; i++)
      apply(mk(0, 1, 13, 'hA3, 1, 12, 'hC, 0, 0, 12, 0,  0, 0, 0, 0,  1, 13, 'hA3));
    apply(mk(0, 1, 13, 'hA3, 1, 12, 'hC, 1, 15, 0, 0,  1, 1, 0, 0,  1, 12, 'hC));

    // Reset in the cycle of a multi-cycle accept drops the write and the busy bit.
    apply(mk(1, 0, 0, 0,     1, 14, 'hE, 0, 0, 15, 0,  1, 0, 1, 0,  0, 0, 0));
    apply(mk(0, 0, 0, 0,     0, 0, 0,    0, 0, 15, 0,  1, 0, 0, 0,  0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
